// File: rtl/lif_tdm_scheduler_pkg.sv
// Shared types and constants for the LIF time-multiplexed scheduler.
// Holds the FSM encoding, the per-neuron state record and the accumulator saturation bounds.
package lif_pkg;

    localparam int DEF_NUM_NEURONS  = 4;
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int DATA_WIDTH       = 16;
    localparam int ACC_WIDTH        = 12;
    localparam int REFR_WIDTH       = 3;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] v;
        logic [REFR_WIDTH-1:0] refr;
    } neuron_t;

endpackage

// File: rtl/lif_tdm_scheduler_if.sv
// Request/result bus between the scheduler (master) and the shared LIF update datapath (slave).
// dp_valid and the dp_* request fields hold steady until the datapath answers with dp_done.
interface lif_tdm_scheduler_if;
    import lif_pkg::*;

    logic                  dp_valid;
    logic [DATA_WIDTH-1:0] dp_v;
    logic [ACC_WIDTH-1:0]  dp_input;
    logic [REFR_WIDTH-1:0] dp_refr;
    logic                  dp_done;
    logic [DATA_WIDTH-1:0] dp_v_nxt;
    logic [REFR_WIDTH-1:0] dp_refr_nxt;
    logic                  dp_spike;

    modport master (
        output dp_valid, dp_v, dp_input, dp_refr,
        input  dp_done, dp_v_nxt, dp_refr_nxt, dp_spike
    );

    modport slave (
        input  dp_valid, dp_v, dp_input, dp_refr,
        output dp_done, dp_v_nxt, dp_refr_nxt, dp_spike
    );

endinterface

// File: rtl/lif_tdm_scheduler_sat_acc.sv
// Combinational signed saturating add of one input weight into an accumulator word.
// Zero latency; clamps to [ACC_MIN, ACC_MAX] instead of wrapping.
module lif_sat_acc
    import lif_pkg::*;
#(
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH
) (
    input  logic [ACC_WIDTH-1:0]    acc,
    input  logic [WEIGHT_WIDTH-1:0] weight,
    output logic [ACC_WIDTH-1:0]    sum
);

    logic [ACC_WIDTH:0] wide;

    // One guard bit: overflow shows up as disagreement between the top two bits.
    always_comb begin
        wide = {acc[ACC_WIDTH-1], acc}
             + {{(ACC_WIDTH+1-WEIGHT_WIDTH){weight[WEIGHT_WIDTH-1]}}, weight};
        if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
            sum = wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            sum = wide[ACC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/lif_tdm_scheduler.sv
// Sweeps NUM_NEURONS virtual LIF neurons through one shared datapath per tick (3 cycles/neuron + 1).
// Waits indefinitely on dp_done; ticks arriving mid-sweep are dropped and flagged as overrun.
module lif_tdm_scheduler
    import lif_pkg::*;
#(
    parameter int NUM_NEURONS  = DEF_NUM_NEURONS,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int IDX_WIDTH    = $clog2(NUM_NEURONS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    in_wr,
    input  logic [IDX_WIDTH-1:0]    in_addr,
    input  logic [WEIGHT_WIDTH-1:0] in_data,
    lif_tdm_scheduler_if.master     dp,
    output logic                    spike_valid,
    output logic [IDX_WIDTH-1:0]    spike_id,
    output logic                    busy,
    output logic                    sweep_done,
    output logic [15:0]             ts_count,
    output logic                    overrun
);

    state_t               state;
    logic [IDX_WIDTH-1:0] idx;
    neuron_t              cap;
    neuron_t              nst [NUM_NEURONS];
    logic [ACC_WIDTH-1:0] acc [NUM_NEURONS];
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [ACC_WIDTH-1:0] in_sext;

    assign in_sext = {{(ACC_WIDTH-WEIGHT_WIDTH){in_data[WEIGHT_WIDTH-1]}}, in_data};

    lif_sat_acc #(
        .WEIGHT_WIDTH (WEIGHT_WIDTH)
    ) u_sat_acc (
        .acc    (acc[in_addr]),
        .weight (in_data),
        .sum    (acc_sum)
    );

    // A write that collides with the ISSUE-cycle clear starts the next timestep's sum.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (rst) begin
                acc[i] <= '0;
            end else if (in_wr && in_addr == IDX_WIDTH'(i)) begin
                acc[i] <= (state == S_ISSUE && idx == IDX_WIDTH'(i)) ? in_sext : acc_sum;
            end else if (state == S_ISSUE && idx == IDX_WIDTH'(i)) begin
                acc[i] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            cap         <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                nst[i] <= '0;
            end
            dp.dp_valid <= 1'b0;
            dp.dp_v     <= '0;
            dp.dp_input <= '0;
            dp.dp_refr  <= '0;
            spike_valid <= 1'b0;
            spike_id    <= '0;
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
            ts_count    <= '0;
            overrun     <= 1'b0;
        end else begin
            spike_valid <= 1'b0;
            sweep_done  <= 1'b0;
            if (tick && state != S_IDLE) begin
                overrun <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (tick) begin
                        state <= S_ISSUE;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    dp.dp_valid <= 1'b1;
                    dp.dp_v     <= nst[idx].v;
                    dp.dp_input <= acc[idx];
                    dp.dp_refr  <= nst[idx].refr;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (dp.dp_done) begin
                        cap.v       <= dp.dp_v_nxt;
                        cap.refr    <= dp.dp_refr_nxt;
                        dp.dp_valid <= 1'b0;
                        spike_valid <= dp.dp_spike;
                        if (dp.dp_spike) begin
                            spike_id <= idx;
                        end
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    nst[idx] <= cap;
                    if (idx == IDX_WIDTH'(NUM_NEURONS - 1)) begin
                        state      <= S_DONE;
                        sweep_done <= 1'b1;
                        ts_count   <= ts_count + 16'd1;
                    end else begin
                        idx   <= idx + IDX_WIDTH'(1);
                        state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Directed bench for lif_tdm_scheduler with a behavioural datapath stub and a per-neuron model.
module tb_lif_tdm_scheduler;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       in_wr = 1'b0;
    logic [1:0] in_addr = '0;
    logic [7:0] in_data = '0;
    logic       spike_valid;
    logic [1:0] spike_id;
    logic       busy;
    logic       sweep_done;
    logic [15:0] ts_count;
    logic       overrun;

    lif_tdm_scheduler_if dpif ();

    lif_tdm_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .in_wr       (in_wr),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .dp          (dpif),
        .spike_valid (spike_valid),
        .spike_id    (spike_id),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .ts_count    (ts_count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Datapath stub: v += input (floor 0), fires at >= 0x100 and resets v, refractory 3 after a spike.
    int   req_cnt = 0;
    int   wcnt = 0;
    int   slow_at = -1;
    logic stray_done = 1'b0;
    int   dp_sum;

    always_comb begin
        dp_sum = int'(dpif.dp_v) + int'(signed'(dpif.dp_input));
        if (dp_sum < 0) dp_sum = 0;
        dpif.dp_spike    = (dp_sum >= 256);
        dpif.dp_v_nxt    = dpif.dp_spike ? 16'h0000 : 16'(dp_sum);
        dpif.dp_refr_nxt = dpif.dp_spike ? 3'd3 : ((dpif.dp_refr != 3'd0) ? dpif.dp_refr - 3'd1 : 3'd0);
        dpif.dp_done     = stray_done || (dpif.dp_valid && (req_cnt != slow_at || wcnt >= 5));
    end

    always @(posedge clk) begin
        if (dpif.dp_valid && dpif.dp_done) begin
            req_cnt <= req_cnt + 1;
            wcnt    <= 0;
        end else if (dpif.dp_valid) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    // Monitor: records the request seen for each sweep position, spikes, sweeps and request stability.
    logic [11:0] seen_in   [N];
    logic [15:0] seen_v    [N];
    logic [2:0]  seen_refr [N];
    int          spike_cnt [N];
    int          sweeps = 0;
    int          unstable = 0;
    int          k = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] prev_v = '0;
    logic [11:0] prev_in = '0;

    always @(negedge clk) begin
        if (rst) begin
            k = 0;
        end else begin
            if (dpif.dp_valid && !prev_valid && k < N) begin
                seen_in[k]   = dpif.dp_input;
                seen_v[k]    = dpif.dp_v;
                seen_refr[k] = dpif.dp_refr;
            end
            if (dpif.dp_valid && prev_valid && (dpif.dp_v != prev_v || dpif.dp_input != prev_in))
                unstable = unstable + 1;
            if (dpif.dp_valid && dpif.dp_done) k = k + 1;
            if (spike_valid) spike_cnt[spike_id] = spike_cnt[spike_id] + 1;
            if (sweep_done) begin
                k = 0;
                sweeps = sweeps + 1;
            end
        end
        prev_valid = dpif.dp_valid;
        prev_v     = dpif.dp_v;
        prev_in    = dpif.dp_input;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference neuron state kept by the bench.
    int mv [N];
    int mr [N];
    int macc [N];
    int last_spk [N];

    function automatic int sat_add(input int a, input logic [7:0] w);
        int s;
        s = a + int'(signed'(w));
        if (s > 2047) s = 2047;
        if (s < -2048) s = -2048;
        return s;
    endfunction

    task automatic wr(input int addr, input logic [7:0] data);
        in_wr   = 1'b1;
        in_addr = 2'(addr);
        in_data = data;
        @(posedge clk); #1;
        in_wr = 1'b0;
        macc[addr] = sat_add(macc[addr], data);
    endtask

    task automatic reset_model();
        for (int i = 0; i < N; i++) begin
            mv[i] = 0; mr[i] = 0; macc[i] = 0;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dp_valid"}, int'(dpif.dp_valid), 0);
        check({tag, "_dp_v"}, int'(dpif.dp_v), 0);
        check({tag, "_dp_input"}, int'(dpif.dp_input), 0);
        check({tag, "_dp_refr"}, int'(dpif.dp_refr), 0);
        check({tag, "_spike_valid"}, int'(spike_valid), 0);
        check({tag, "_spike_id"}, int'(spike_id), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_sweep_done"}, int'(sweep_done), 0);
        check({tag, "_ts_count"}, int'(ts_count), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    // wr_at == 0 writes in the tick cycle (counts now); wr_at > 0 must be at or after that neuron's ISSUE.
    task automatic sweep_and_check(input int extra_tick_at, input int wr_at, input int wr_addr,
                                   input logic [7:0] wr_data, input int exp_cycles);
        int cyc, ts0, s, spk;
        int acc_s [N];
        int spk0 [N];
        ts0 = int'(ts_count);
        if (wr_at == 0) macc[wr_addr] = sat_add(macc[wr_addr], wr_data);
        for (int i = 0; i < N; i++) begin
            acc_s[i] = macc[i];
            spk0[i]  = spike_cnt[i];
        end
        tick    = 1'b1;
        in_wr   = (wr_at == 0);
        in_addr = 2'(wr_addr);
        in_data = wr_data;
        @(posedge clk); #1;
        tick  = 1'b0;
        in_wr = 1'b0;
        cyc   = 1;
        while (!sweep_done && cyc < 200) begin
            tick  = (cyc == extra_tick_at);
            in_wr = (cyc == wr_at);
            @(posedge clk); #1;
            tick  = 1'b0;
            in_wr = 1'b0;
            cyc++;
        end
        check("sweep_cycles", cyc, exp_cycles);
        @(posedge clk); #1;
        check("busy_after_sweep", int'(busy), 0);
        check("ts_count_step", int'(ts_count), (ts0 + 1) & 16'hFFFF);
        for (int i = 0; i < N; i++) begin
            s = mv[i] + acc_s[i];
            if (s < 0) s = 0;
            spk = (s >= 256) ? 1 : 0;
            check($sformatf("dp_input[%0d]", i), int'(seen_in[i]), acc_s[i] & 12'hFFF);
            check($sformatf("dp_v[%0d]", i), int'(seen_v[i]), mv[i]);
            check($sformatf("dp_refr[%0d]", i), int'(seen_refr[i]), mr[i]);
            last_spk[i] = spike_cnt[i] - spk0[i];
            check($sformatf("spikes[%0d]", i), last_spk[i], spk);
            mr[i]   = spk ? 3 : ((mr[i] > 0) ? mr[i] - 1 : 0);
            mv[i]   = spk ? 0 : s;
            macc[i] = 0;
        end
        if (wr_at > 0) macc[wr_addr] = int'(signed'(wr_data));
    endtask

    typedef struct {
        int          addr;
        logic [7:0]  data;
        int          n;
        logic [11:0] exp_in;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int ts0, sw0;
        tbl[0] = '{addr: 2, data: 8'h7F, n: 2,  exp_in: 12'h0FE};
        tbl[1] = '{addr: 1, data: 8'h7F, n: 40, exp_in: 12'h7FF};
        tbl[2] = '{addr: 1, data: 8'h80, n: 40, exp_in: 12'h800};
        tbl[3] = '{addr: 0, data: 8'h05, n: 3,  exp_in: 12'h00F};
        tbl[4] = '{addr: 3, data: 8'hFF, n: 4,  exp_in: 12'hFFC};
        tbl[5] = '{addr: 0, data: 8'h80, n: 1,  exp_in: 12'hF80};
        for (int i = 0; i < N; i++) spike_cnt[i] = 0;
        reset_model();

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_zero("reset");

        // Idle sweep with zero-wait datapath.
        sweep_and_check(-1, -1, 0, 8'h00, 13);
        check("first_ts_count", int'(ts_count), 1);

        // Preload v[2]=2 so two 0x7F writes push it over threshold.
        wr(2, 8'h02);
        sweep_and_check(-1, -1, 0, 8'h00, 13);

        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < tbl[t].n; j++) wr(tbl[t].addr, tbl[t].data);
            sweep_and_check(-1, -1, 0, 8'h00, 13);
            check($sformatf("tbl%0d_input", t), int'(seen_in[tbl[t].addr]), int'(tbl[t].exp_in));
            if (t == 0) check("spike_on_n2", last_spk[2], 1);
        end
        sweep_and_check(-1, -1, 0, 8'h00, 13);
        check("acc2_cleared", int'(seen_in[2]), 0);

        // dp_done while dp_valid is low must not start anything.
        sw0 = sweeps;
        ts0 = int'(ts_count);
        stray_done = 1'b1;
        repeat (3) @(posedge clk);
        #1 stray_done = 1'b0;
        check("stray_busy", int'(busy), 0);
        check("stray_sweeps", sweeps, sw0);
        check("stray_ts", int'(ts_count), ts0);

        // Write landing on neuron 3's ISSUE cycle (cycle 10) belongs to the next timestep.
        wr(3, 8'h10);
        sweep_and_check(-1, 10, 3, 8'h25, 13);
        check("coincide_now", int'(seen_in[3]), 12'h010);
        sweep_and_check(-1, -1, 0, 8'h00, 13);
        check("coincide_next", int'(seen_in[3]), 12'h025);

        // Write in the tick cycle counts for this sweep.
        sweep_and_check(-1, 0, 0, 8'h11, 13);
        check("tick_cycle_write", int'(seen_in[0]), 12'h011);

        // Slow datapath on neuron 0 plus a tick mid-sweep.
        check("overrun_before", int'(overrun), 0);
        ts0 = int'(ts_count);
        slow_at = req_cnt;
        sweep_and_check(7, -1, 0, 8'h00, 18);
        slow_at = -1;
        check("wait_stable", unstable, 0);
        check("overrun_set", int'(overrun), 1);
        repeat (5) @(posedge clk);
        #1;
        check("no_queued_sweep", int'(busy), 0);
        check("ts_once", int'(ts_count), (ts0 + 1) & 16'hFFFF);

        // Reset while neuron 1 waits on the datapath.
        wr(0, 8'h40);
        wr(2, 8'h30);
        sw0 = sweeps;
        slow_at = req_cnt + 1;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_waiting", int'(dpif.dp_valid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        slow_at = -1;
        check_zero("midrst");
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_sweep", sweeps, sw0);
        reset_model();
        sweep_and_check(-1, -1, 0, 8'h00, 13);
        check("post_rst_ts", int'(ts_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lif_tdm_scheduler.md
Name: lif_tdm_scheduler

Overview:
Time-division-multiplexed sequencer that shares one external LIF update datapath across NUM_NEURONS virtual neurons. It holds per-neuron membrane and refractory state plus an input accumulator. On each timestep tick it sweeps the neurons in index order through the datapath using a valid/done handshake, writes the results back, and reports spikes as indexed events. It sits between the host/pin-interface logic and the LIF update core.

Parameters:
NUM_NEURONS, 4, virtual neurons scheduled; power of two, 2..16
DATA_WIDTH, 16, membrane potential width, unsigned
WEIGHT_WIDTH, 8, signed input weight width per write
ACC_WIDTH, 12, signed saturating input accumulator width (> WEIGHT_WIDTH)
REFR_WIDTH, 3, refractory counter width
IDX_WIDTH, $clog2(NUM_NEURONS), neuron index width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  timestep strobe, one-cycle pulse
in_wr  in  1  accumulate in_data into the buffer of neuron in_addr
in_addr  in  IDX_WIDTH  target neuron
in_data  in  WEIGHT_WIDTH  signed weight
dp_valid  out  1  request to datapath; held until dp_done
dp_v  out  DATA_WIDTH  membrane of the current neuron
dp_input  out  ACC_WIDTH  accumulated input of the current neuron
dp_refr  out  REFR_WIDTH  refractory count of the current neuron
dp_done  in  1  datapath result valid; sampled only while dp_valid=1
dp_v_nxt  in  DATA_WIDTH  updated membrane
dp_refr_nxt  in  REFR_WIDTH  updated refractory count
dp_spike  in  1  neuron fired this timestep
spike_valid  out  1  one-cycle pulse per fired neuron
spike_id  out  IDX_WIDTH  index of the fired neuron
busy  out  1  sweep in progress
sweep_done  out  1  one-cycle pulse at sweep end
ts_count  out  16  completed timesteps, wraps at 65535->0
overrun  out  1  sticky: a tick arrived while busy

Behaviour:
- Reset: all outputs are 0. Membrane, refractory and accumulator arrays are cleared to 0. FSM enters IDLE. rst has priority over every other input.
- FSM states: IDLE, ISSUE, WAIT, WB, DONE.
- IDLE: a tick moves the FSM to ISSUE with idx=0 and sets busy=1 in the next cycle.
- ISSUE, one cycle:
  - Latch state[idx] onto the dp_* outputs and assert dp_valid.
  - Clear acc[idx] to 0 in the same cycle.
  - Go to WAIT.
- WAIT:
  - dp_valid and the dp_* outputs stay stable until dp_done=1.
  - dp_done may arrive in the first WAIT cycle or later; there is no timeout.
  - On dp_done, capture dp_v_nxt, dp_refr_nxt and dp_spike, drop dp_valid, and go to WB.
  - A dp_done seen while dp_valid=0 is ignored.
- WB, one cycle:
  - Write the captured values into state[idx].
  - If the captured spike is 1: spike_valid=1 and spike_id=idx in this cycle.
  - If idx=NUM_NEURONS-1, go to DONE; otherwise increment idx and go to ISSUE.
- DONE, one cycle: sweep_done=1, ts_count increments, busy=0 in the next cycle, go to IDLE.
- Per-neuron cost: ISSUE 1 cycle + WAIT ≥1 cycle + WB 1 cycle. With a zero-wait datapath (dp_done in the first WAIT cycle), tick to sweep_done is 3*NUM_NEURONS+1 cycles.
- Input accumulation is accepted in every state:
  - acc[a] <= sat(acc[a] + sext(in_data)), saturating to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - If in_wr targets the neuron being cleared in ISSUE in that same cycle, acc[a] <= sext(in_data). That write counts toward the next timestep and is not lost.
- Tick while busy (including the DONE cycle) is ignored, sets overrun=1, and does not queue. overrun clears only on rst.
- tick and in_wr in the same cycle from IDLE: the write lands before neuron 0 is issued, so it counts this timestep.
- Reset mid-sweep: the sweep is abandoned, dp_valid drops immediately, and no spike or sweep_done is emitted.

Decomposition:
- Shared package lif_pkg holds:
  - FSM state enum.
  - Neuron-state struct {v, refr}.
  - Saturation min/max constants derived from ACC_WIDTH.
- One sub-module is natural: lif_sat_acc, a combinational signed saturating adder of WEIGHT_WIDTH into ACC_WIDTH.
- State arrays stay inside the top as register arrays; there is no SRAM macro.

Test Plan:
- Zero-wait datapath model (dp_v_nxt=dp_v+dp_input, spike when ≥0x0100), tick with no input -> sweep_done exactly 13 cycles after tick, ts_count=1, no spike_valid.
- Writes neuron 2 += 0x7F, then += 0x7F, then tick -> dp_input=0x0FE seen for idx 2; acc[2]=0 after its ISSUE; spike_valid with spike_id=2 because 0xFE+0x02 preload crosses 0x0100.
- 40 writes of 0x7F to neuron 1 -> dp_input saturates at 0x7FF. Then 40 writes of 0x80 -> 0x800.
- Datapath delays dp_done by 5 cycles on neuron 0 -> dp_valid and dp_v stable throughout; tick issued mid-sweep -> overrun=1, ts_count advances by 1 only.
- in_wr to neuron 3 coincident with its ISSUE cycle -> current dp_input excludes the weight; next sweep's dp_input equals that weight.
- rst asserted during WAIT of neuron 1 -> next cycle all outputs 0, arrays cleared; a following tick starts a clean sweep from idx 0.
